cla_wide_add_seq: RTL and testbench

CLA_WIDE_ADD_SEQ -- requirements
Module: cla_wide_add_seq

---
 rtl/cla_pkg.sv | 12 +
 rtl/carry_look_ahead_16bit.sv | 56 +++++
 rtl/cla_wide_add_seq.sv | 118 +++++++++++
 tb/tb_cla_wide_add_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and FSM state encoding for the sequential wide adder.
package cla_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_look_ahead_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// and a lookahead stage resolving the group carries directly from cin.
module carry_look_ahead_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    logic [15:0] c;

    // Group propagate / generate terms
    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
    end

    // Lookahead across groups, all carries expressed in terms of cin
    always_comb begin
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])   | (p[4*j+1] & p[4*j]   & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        sum  = p ^ c;
        cout = gc[4];
    end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Sequential wide add/subtract: one shared 16-bit CLA processes one slice per
// cycle, carry rippling through a register between slices.
module cla_wide_add_seq
    import cla_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*WORDS-1:0]    a,
    input  logic [SLICE_W*WORDS-1:0]    b,
    input  logic                        cin,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*WORDS-1:0]    sum,
    output logic                        cout,
    output logic                        busy
);

    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t state_q;
    state_t state_d;

    logic [WORDS-1:0][SLICE_W-1:0] a_q;
    logic [WORDS-1:0][SLICE_W-1:0] b_q;
    logic [WORDS-1:0][SLICE_W-1:0] sum_q;
    logic [KW-1:0]                 k_q;
    logic                          carry_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          busy_q;

    logic                          last_c;
    logic [SLICE_W-1:0]            cla_sum;
    logic                          cla_cout;

    assign last_c = (k_q == KW'(WORDS - 1));

    carry_look_ahead_16bit u_cla (
        .a    (a_q[k_q]),
        .b    (b_q[k_q]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they line up with state_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Operand capture and slice-serial accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q[k_q] <= cla_sum;
                    carry_q    <= cla_cout;
                    if (!last_c) begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq (WORDS=4) with hand-computed results.
module tb_cla_wide_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    cla_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one operation, verify latency and result, then drain it
    task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [63:0] esum, input logic ecout);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "_lat"}, 64'(n), 64'd4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, 64'(cout), 64'(ecout));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [63:0] hold_sum;
    logic        hold_cout;
    logic        seen;
    int          n;
    int          acc;
    int          res;
    int          cyc;
    int          acc_cyc [3];
    logic [63:0] bb_a   [3];
    logic [63:0] bb_b   [3];
    logic [63:0] bb_exp [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_sum",       sum,              64'd0);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_busy",      64'(busy),        64'd0);
        check("rst_cout",      64'(cout),        64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready",  64'(in_ready),    64'd1);

        run_op("carry",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        run_op("slice",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
        run_op("sub0m1", 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("sub5m3", 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b1);
        run_op("msb",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1);
        run_op("mixed",  64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0,
               64'h0001_0000_0001_0001, 1'b0);

        // Backpressure: result must hold while out_ready is low, new inputs ignored
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_sum", sum, 64'h2345_6789_ABCD_F001);
        check("bp_cout", 64'(cout), 64'd0);
        hold_sum = sum; hold_cout = cout;
        a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h5555_5555_5555_5555; in_valid = 1'b1; sub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_sum",   sum,            64'h2345_6789_ABCD_F001);
            check("bp_hold_cout",  64'(cout),      64'(hold_cout));
            check("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_drain_valid", 64'(out_valid), 64'd0);
        check("bp_drain_ready", 64'(in_ready),  64'd1);

        // Reset two cycles into RUN abandons the operation
        a = 64'h0000_0000_0000_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_sum",   sum,            64'd0);
        check("mrst_busy",  64'(busy),      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("mrst_no_valid", 64'(seen), 64'd0);
        run_op("post_rst", 64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0);

        // Back-to-back: in_valid held high, out_ready held high
        bb_a[0] = 64'd10;                    bb_b[0] = 64'd20;  bb_exp[0] = 64'd30;
        bb_a[1] = 64'h0000_0000_FFFF_FFFF;   bb_b[1] = 64'd1;   bb_exp[1] = 64'h0000_0001_0000_0000;
        bb_a[2] = 64'd7;                     bb_b[2] = 64'd9;   bb_exp[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        acc = 0; res = 0; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0;
        a = bb_a[0]; b = bb_b[0]; sub = 1'b0;
        while (res < 3 && cyc < 100) begin
            if (out_valid) begin
                check("b2b_sum", sum, bb_exp[res]);
                res++;
            end
            if (in_ready && in_valid) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc < 3) begin
                a = bb_a[acc]; b = bb_b[acc]; sub = (acc == 2);
            end else begin
                in_valid = 1'b0;
            end
        end
        check("b2b_results", 64'(res), 64'd3);
        check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(WORDS + 2));
        check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(WORDS + 2));
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
